zoom_pipe: RTL and testbench

Parametrised, pipelined coordinate scaler for the graphics path: it scales a signed (X,Y) point by an unsigned fixed-point zoom factor, adds a per-beat pan offset, and range-checks or saturates the result to the coordinate width. It replaces the single-cycle 8-bit zoom stage with a 3-stage valid/ready pipeline. It sits between the coordinate generator and the rasteriser/address stage.

---
 rtl/zoom_pipe.sv | 123 ++++++++++++
 tb/tb_zoom_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zoom_pipe.sv
// zoom_pipe: 3-stage valid/ready pipeline that scales a signed point by an unsigned
// fixed-point zoom, adds a pan offset and zeroes or saturates results that do not fit.
module zoom_pipe #(
    parameter int COORD_W = 8,
    parameter int ZOOM_W = 8,
    parameter int FRAC_W = 4,
    parameter int CLIP_MODE = 0
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               ENB,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [COORD_W-1:0] Xcoord,
    input  logic [COORD_W-1:0] Ycoord,
    input  logic [ZOOM_W-1:0]  Zoom,
    input  logic [COORD_W-1:0] Xpan,
    input  logic [COORD_W-1:0] Ypan,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [COORD_W-1:0] Xout,
    output logic [COORD_W-1:0] Yout,
    output logic               RANGE_OK
);
    localparam int MW = COORD_W + 1;
    localparam int PW = MW + ZOOM_W;
    localparam int SW = PW - FRAC_W;
    localparam int RW = SW + 2;
    localparam logic signed [RW-1:0] LO = RW'(-(2 ** (COORD_W - 1)));
    localparam logic signed [RW-1:0] HI = RW'(2 ** (COORD_W - 1) - 1);
    localparam logic [COORD_W-1:0] SAT_LO = {1'b1, {(COORD_W - 1){1'b0}}};
    localparam logic [COORD_W-1:0] SAT_HI = {1'b0, {(COORD_W - 1){1'b1}}};

    logic               advance, live, v1, v2;
    logic               sx1, sy1, sx2, sy2;
    logic [MW-1:0]      mx1, my1;
    logic [ZOOM_W-1:0]  z1;
    logic [COORD_W-1:0] px1, py1, px2, py2;
    logic [PW-1:0]      prx, pry;
    logic [SW-1:0]      qx2, qy2;
    logic signed [RW-1:0] rx, ry;
    logic               okx, oky;
    logic [COORD_W-1:0] nx, ny;

    // live keeps IN_READY low through reset without feeding the reset net into datapath enables
    assign advance  = !OUT_VALID || OUT_READY;
    assign IN_READY = ENB && advance && live;

    function automatic logic [MW-1:0] mag(input logic [COORD_W-1:0] v);
        return v[COORD_W-1] ? MW'(-{v[COORD_W-1], v}) : {v[COORD_W-1], v};
    endfunction

    function automatic logic signed [RW-1:0] signed_sum(input logic s, input logic [SW-1:0] q,
                                                        input logic [COORD_W-1:0] p);
        logic signed [RW-1:0] m;
        m = $signed({2'b00, q});
        return (s ? -m : m) + $signed({{(RW - COORD_W){p[COORD_W-1]}}, p});
    endfunction

    function automatic logic [COORD_W-1:0] sat(input logic signed [RW-1:0] r);
        return r < LO ? SAT_LO : r > HI ? SAT_HI : r[COORD_W-1:0];
    endfunction

    always_comb begin
        prx = PW'(mx1) * PW'(z1);
        pry = PW'(my1) * PW'(z1);
        rx  = signed_sum(sx2, qx2, px2);
        ry  = signed_sum(sy2, qy2, py2);
        okx = rx >= LO && rx <= HI;
        oky = ry >= LO && ry <= HI;
        nx  = okx && oky ? rx[COORD_W-1:0] : CLIP_MODE == 0 ? '0 : sat(rx);
        ny  = okx && oky ? ry[COORD_W-1:0] : CLIP_MODE == 0 ? '0 : sat(ry);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            live      <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            OUT_VALID <= 1'b0;
            Xout      <= '0;
            Yout      <= '0;
            RANGE_OK  <= 1'b0;
        end else begin
            live <= 1'b1;
            if (!ENB) begin
                v1        <= 1'b0;
                v2        <= 1'b0;
                OUT_VALID <= 1'b0;
            end else if (advance) begin
                v1        <= IN_VALID && live;
                v2        <= v1;
                OUT_VALID <= v2;
                if (v2) begin
                    Xout     <= nx;
                    Yout     <= ny;
                    RANGE_OK <= okx && oky;
                end
            end
        end
    end

    // datapath registers load only with a valid beat, so flushed stages keep their last data
    always_ff @(posedge ACLK) begin
        if (IN_VALID && IN_READY) begin
            sx1 <= Xcoord[COORD_W-1];
            sy1 <= Ycoord[COORD_W-1];
            mx1 <= mag(Xcoord);
            my1 <= mag(Ycoord);
            z1  <= Zoom;
            px1 <= Xpan;
            py1 <= Ypan;
        end
        if (ENB && advance && v1) begin
            sx2 <= sx1;
            sy2 <= sy1;
            qx2 <= SW'(prx >> FRAC_W);
            qy2 <= SW'(pry >> FRAC_W);
            px2 <= px1;
            py2 <= py1;
        end
    end
endmodule

// File: tb/tb_zoom_pipe.sv
// tb_zoom_pipe: drives a CLIP_MODE=0 and a CLIP_MODE=1 instance in lockstep and checks
// both against a scoreboard fed by an arithmetic model of the zoom/pan/clip rules.
module tb_zoom_pipe;
    localparam int W = 8;
    localparam int ZW = 8;
    localparam int F = 4;
    localparam int LIM_LO = -(2 ** (W - 1));
    localparam int LIM_HI = 2 ** (W - 1) - 1;

    typedef struct {
        int x0, y0, ok0, x1, y1, ok1;
    } exp_t;

    typedef struct {
        int x, y, z, xp, yp, ex0, ey0, ok0, ex1, ey1, ok1;
    } vec_t;

    logic ACLK = 1'b0;
    logic ARESET, ENB, IN_VALID, OUT_READY;
    logic [W-1:0] Xcoord, Ycoord, Xpan, Ypan;
    logic [ZW-1:0] Zoom;
    logic ir0, ov0, ok0, ir1, ov1, ok1;
    logic [W-1:0] x0, y0, x1, y1;

    int checks = 0;
    int errors = 0;
    int delivered = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    bit stall_prev = 0;
    longint held = 0;

    zoom_pipe #(.COORD_W(W), .ZOOM_W(ZW), .FRAC_W(F), .CLIP_MODE(0)) dut0 (
        .ACLK(ACLK), .ARESET(ARESET), .ENB(ENB), .IN_VALID(IN_VALID), .IN_READY(ir0),
        .Xcoord(Xcoord), .Ycoord(Ycoord), .Zoom(Zoom), .Xpan(Xpan), .Ypan(Ypan),
        .OUT_VALID(ov0), .OUT_READY(OUT_READY), .Xout(x0), .Yout(y0), .RANGE_OK(ok0)
    );

    zoom_pipe #(.COORD_W(W), .ZOOM_W(ZW), .FRAC_W(F), .CLIP_MODE(1)) dut1 (
        .ACLK(ACLK), .ARESET(ARESET), .ENB(ENB), .IN_VALID(IN_VALID), .IN_READY(ir1),
        .Xcoord(Xcoord), .Ycoord(Ycoord), .Zoom(Zoom), .Xpan(Xpan), .Ypan(Ypan),
        .OUT_VALID(ov1), .OUT_READY(OUT_READY), .Xout(x1), .Yout(y1), .RANGE_OK(ok1)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int sv(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int clamp(input int v);
        return v < LIM_LO ? LIM_LO : v > LIM_HI ? LIM_HI : v;
    endfunction

    // integer division truncates toward zero, which is exactly the magnitude-truncation rule
    function automatic exp_t model(input int x, input int y, input int z, input int xp, input int yp);
        exp_t e;
        int rx, ry;
        bit fit;
        rx = x * z / (2 ** F) + xp;
        ry = y * z / (2 ** F) + yp;
        fit = rx >= LIM_LO && rx <= LIM_HI && ry >= LIM_LO && ry <= LIM_HI;
        e.ok0 = int'(fit);
        e.ok1 = int'(fit);
        e.x0 = fit ? rx : 0;
        e.y0 = fit ? ry : 0;
        e.x1 = clamp(rx);
        e.y1 = clamp(ry);
        return e;
    endfunction

    function automatic longint snap();
        return longint'({x0, y0, ok0, x1, y1, ok1});
    endfunction

    always @(negedge ACLK) begin
        if (ARESET) begin
            exp_q.delete();
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", ov0, 1);
                check("hold_data", snap(), held);
            end
            if (ov0 && OUT_READY) begin
                check("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("sb_x0", sv(x0), mon_e.x0);
                    check("sb_y0", sv(y0), mon_e.y0);
                    check("sb_ok0", ok0, mon_e.ok0);
                    check("sb_x1", sv(x1), mon_e.x1);
                    check("sb_y1", sv(y1), mon_e.y1);
                    check("sb_ok1", ok1, mon_e.ok1);
                    check("sb_valid1", ov1, 1);
                end
                delivered++;
            end
            if (!ENB) exp_q.delete();
            if (IN_VALID && ir0)
                exp_q.push_back(model(sv(Xcoord), sv(Ycoord), int'(Zoom), sv(Xpan), sv(Ypan)));
            stall_prev = ov0 && !OUT_READY && ENB;
            held = snap();
        end
    end

    task automatic drive(input int x, input int y, input int z, input int xp, input int yp);
        Xcoord = W'(x);
        Ycoord = W'(y);
        Zoom   = ZW'(z);
        Xpan   = W'(xp);
        Ypan   = W'(yp);
    endtask

    // call at posedge+1; returns at the negedge where OUT_VALID is first seen
    task automatic send_one(input int x, input int y, input int z, input int xp, input int yp,
                            output int waits, output int lat);
        drive(x, y, z, xp, yp);
        IN_VALID = 1'b1;
        waits = 0;
        do begin @(negedge ACLK); waits++; end while (!ir0 && waits < 10);
        @(posedge ACLK);
        #1 IN_VALID = 1'b0;
        lat = 0;
        do begin @(negedge ACLK); lat++; end while (!ov0 && lat < 10);
    endtask

    initial begin
        vec_t tbl[14];
        int w, lat, n, d0;
        tbl[0]  = '{10, -5, 32, 0, 0, 20, -10, 1, 20, -10, 1};
        tbl[1]  = '{100, 1, 32, 0, 0, 0, 0, 0, 127, 2, 0};
        tbl[2]  = '{-3, 0, 8, 0, 0, -1, 0, 1, -1, 0, 1};
        tbl[3]  = '{-128, 0, 16, 0, 0, -128, 0, 1, -128, 0, 1};
        tbl[4]  = '{-128, 0, 16, -1, 0, 0, 0, 0, -128, 0, 0};
        tbl[5]  = '{10, 0, 16, -30, 0, -20, 0, 1, -20, 0, 1};
        tbl[6]  = '{55, -77, 0, 7, -9, 7, -9, 1, 7, -9, 1};
        tbl[7]  = '{127, -128, 255, 0, 0, 0, 0, 0, 127, -128, 0};
        tbl[8]  = '{5, 100, 32, 0, 0, 0, 0, 0, 10, 127, 0};
        tbl[9]  = '{0, -64, 32, 0, -1, 0, 0, 0, 0, -128, 0};
        tbl[10] = '{127, 0, 16, 1, 0, 0, 0, 0, 127, 0, 0};
        tbl[11] = '{3, -1, 8, 0, 0, 1, 0, 1, 1, 0, 1};
        tbl[12] = '{127, -128, 16, 0, 0, 127, -128, 1, 127, -128, 1};
        tbl[13] = '{-128, 127, 16, 127, -128, -1, -1, 1, -1, -1, 1};

        ARESET = 1'b1;
        ENB = 1'b1;
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        drive(0, 0, 0, 0, 0);
        #3;
        check("rst_out_valid", ov0, 0);
        check("rst_xout", x0, 0);
        check("rst_yout", y0, 0);
        check("rst_range_ok", ok0, 0);
        check("rst_in_ready", ir0, 0);
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(posedge ACLK);
        #1;

        for (int i = 0; i < 14; i++) begin
            send_one(tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].xp, tbl[i].yp, w, lat);
            check($sformatf("vec%0d_latency", i), lat, 3);
            check($sformatf("vec%0d_x0", i), sv(x0), tbl[i].ex0);
            check($sformatf("vec%0d_y0", i), sv(y0), tbl[i].ey0);
            check($sformatf("vec%0d_ok0", i), ok0, tbl[i].ok0);
            check($sformatf("vec%0d_x1", i), sv(x1), tbl[i].ex1);
            check($sformatf("vec%0d_y1", i), sv(y1), tbl[i].ey1);
            check($sformatf("vec%0d_ok1", i), ok1, tbl[i].ok1);
            @(posedge ACLK);
            #1;
        end

        // six back-to-back beats with a four-cycle downstream stall in the middle
        d0 = delivered;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    drive(i * 7 - 20, 3 * i, 16 + i, i, -i);
                    IN_VALID = 1'b1;
                    n = 0;
                    do begin @(negedge ACLK); n++; end while (!ir0 && n < 20);
                    check("stream_accept", ir0, 1);
                    @(posedge ACLK);
                    #1;
                end
                IN_VALID = 1'b0;
            end
            begin
                repeat (4) @(posedge ACLK);
                #1 OUT_READY = 1'b0;
                repeat (4) begin
                    @(negedge ACLK);
                    check("stall_out_valid", ov0, 1);
                    check("stall_in_ready", ir0, 0);
                end
                @(posedge ACLK);
                #1 OUT_READY = 1'b1;
            end
        join
        repeat (8) @(negedge ACLK);
        check("stream_delivered", delivered - d0, 6);
        check("stream_drained", exp_q.size(), 0);

        // three beats in flight, then one cycle of ENB low drops them all
        @(posedge ACLK);
        #1 OUT_READY = 1'b0;
        drive(1, 1, 16, 0, 0);
        IN_VALID = 1'b1;
        @(posedge ACLK);
        #1 drive(2, 2, 16, 0, 0);
        @(posedge ACLK);
        #1 drive(3, 3, 16, 0, 0);
        @(posedge ACLK);
        #1 IN_VALID = 1'b0;
        ENB = 1'b0;
        check("enb_full_out_valid", ov0, 1);
        check("enb_low_in_ready", ir0, 0);
        @(posedge ACLK);
        #1 check("flush_out_valid", ov0, 0);
        ENB = 1'b1;
        OUT_READY = 1'b1;
        send_one(10, -5, 32, 0, 0, w, lat);
        check("reaccept_wait", w, 1);
        check("reaccept_latency", lat, 3);
        check("reaccept_x0", sv(x0), 20);
        check("reaccept_y0", sv(y0), -10);
        @(posedge ACLK);
        #1;

        // asynchronous reset while a beat is held at the output
        OUT_READY = 1'b0;
        drive(10, 3, 16, 0, 0);
        IN_VALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!ov0 && n < 10);
        check("pre_reset_x0", sv(x0), 10);
        @(posedge ACLK);
        #1 ARESET = 1'b1;
        IN_VALID = 1'b0;
        #1;
        check("areset_out_valid0", ov0, 0);
        check("areset_out_valid1", ov1, 0);
        check("areset_xout", x0, 0);
        check("areset_yout", y0, 0);
        check("areset_range_ok", ok0, 0);
        check("areset_in_ready", ir0, 0);
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        OUT_READY = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge ACLK);
            if (ov0) n++;
        end
        check("post_reset_beats", n, 0);

        // random traffic with random backpressure and occasional flushes
        repeat (400) begin
            @(posedge ACLK);
            #1;
            drive(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                  $urandom_range(0, 1) ? int'($urandom_range(0, 24)) : int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
            IN_VALID = $urandom_range(0, 3) != 0;
            OUT_READY = $urandom_range(0, 9) < 7;
            ENB = $urandom_range(0, 19) != 0;
        end
        @(posedge ACLK);
        #1 IN_VALID = 1'b0;
        ENB = 1'b1;
        OUT_READY = 1'b1;
        repeat (8) @(negedge ACLK);
        check("random_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
